// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: memory-mapped receive FIFO between a UART byte strobe and the
// CPU bus. Data register at BASE (load pops), status at BASE+4, control at BASE+8.
// Handshake: rx_valid is a one-cycle push strobe with no back-pressure; a byte
// arriving while full (and not popped that cycle) is dropped and flagged in the
// sticky overflow bit. rd/wr are single-cycle bus strobes; rdata is combinational.
module uart_rx_fifo #(
  parameter int          DEPTH = 16,
  parameter logic [31:0] BASE  = 32'h40000024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [31:0]   STAT_ADDR = BASE + 32'd4;
  localparam logic [31:0]   CTRL_ADDR = BASE + 32'd8;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic [7:0]    thr_q, thr_d;
  logic          irq_q, irq_d;

  logic hit_data, hit_stat, hit_ctrl;
  logic full, empty, pop, push, flush, ovf_evt;

  // Bits of wdata that no register field uses.
  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:16], wdata[7:3], wdata[1]};

  // Decode bus strobes into FIFO events; flush discards a same-cycle push and pop.
  always_comb begin
    hit_data = (addr == BASE);
    hit_stat = (addr == STAT_ADDR);
    hit_ctrl = (addr == CTRL_ADDR);
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    flush    = wr && hit_data && wdata[0];
    pop      = rd && hit_data && !empty && !flush;
    push     = rx_valid && (!full || pop) && !flush;
    ovf_evt  = rx_valid && full && !pop && !flush;
  end

  // Next-state for pointers, count, overflow, control and the registered irq.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    irq_d    = 1'b0;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A same-cycle overflow event beats the software clear.
    if (wr && hit_stat && wdata[2]) ovf_d = 1'b0;
    if (ovf_evt) ovf_d = 1'b1;

    if (wr && hit_ctrl) begin
      irq_en_d = wdata[0];
      thr_d    = (wdata[15:8] == 8'd0) ? 8'd1 : wdata[15:8];
    end

    // irq is computed from next state so it changes on the same edge as count.
    irq_d = irq_en_d && (9'(count_d) >= {1'b0, thr_d});
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thr_q    <= 8'd1;
      irq_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
      irq_q    <= irq_d;
    end
  end

  // Storage array; contents are not reset, only the write is gated.
  always_ff @(posedge clk) begin
    if (reset && push) mem[tail_q] <= rx_data;
  end

  // Combinational read mux; an empty data read returns zero.
  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (hit_data && !empty) rdata = {24'b0, mem[head_q]};
      else if (hit_stat)      rdata = {16'b0, 8'(count_q), 4'b0, irq_q, ovf_q, full, empty};
      else if (hit_ctrl)      rdata = {16'b0, thr_q, 7'b0, irq_en_q};
    end
  end

  assign irq = irq_q;

endmodule
